// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter in front of a synchronous memory.
// Requester 0 is the processor, requester 1 is the DMA engine.
// Optional build macro ARB_RR_EN: round-robin tie-break (requester other than
// the last owner wins). Without it, requester 0 always wins ties.
// Read: IDLE -> ACCESS (gnt) -> WAIT (capture mem_rdata) -> RESP (rvalid).
// Write: IDLE -> ACCESS (gnt, mem_we) -> IDLE.
module mem_arbiter #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 16
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          req0,
  input  logic          req1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic          we0,
  input  logic          we1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t state;
  logic   owner;
  logic   pick1;

`ifdef ARB_RR_EN
  logic   last_owner;
`endif

  // Winner selection among requests currently presented in IDLE
  always_comb begin
    pick1 = 1'b0;
`ifdef ARB_RR_EN
    if (req0 && req1) begin
      pick1 = ~last_owner;
    end else begin
      pick1 = req1;
    end
`else
    pick1 = req1 && !req0;
`endif
  end

  // Arbiter FSM with registered grant, response and memory-side outputs
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state     <= IDLE;
      owner     <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
`ifdef ARB_RR_EN
      last_owner <= 1'b1;
`endif
    end else begin
      // Pulse outputs default low; mem_addr/mem_wdata/rdata hold
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      mem_we  <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner     <= pick1;
            mem_addr  <= pick1 ? addr1  : addr0;
            mem_wdata <= pick1 ? wdata1 : wdata0;
            mem_we    <= pick1 ? we1    : we0;
            gnt0      <= ~pick1;
            gnt1      <= pick1;
`ifdef ARB_RR_EN
            last_owner <= pick1;
`endif
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          // mem_we is high here only for a write transaction
          state <= mem_we ? IDLE : WAIT;
        end
        WAIT: begin
          rdata   <= mem_rdata;
          rvalid0 <= ~owner;
          rvalid1 <= owner;
          state   <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
